// File: rtl/loader_pkg.sv
// Shared definitions for the value loader and the downstream sorter datapath,
// so both sides agree on the FSM encoding and the packed entries layout.
package loader_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } load_state_e;

    localparam int DEFAULT_DATA_W          = 4;
    localparam int DEFAULT_DEPTH           = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // A one-entry buffer still needs a one-bit write index.
    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces a raw active-low pushbutton, emitting a single
// one-cycle press pulse for each accepted release-to-press transition.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_0;
    logic             btn_s;
    logic             stable_lvl;
    logic             prev_lvl;
    logic [CNT_W-1:0] counter;
    logic [1:0]       warm;
    logic             armed;

    // A button held through reset must not count as a press: pulses are only
    // armed once the synchronized button has been seen released after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_0     <= 1'b1;
            btn_s      <= 1'b1;
            stable_lvl <= 1'b1;
            prev_lvl   <= 1'b1;
            counter    <= '0;
            warm       <= 2'b00;
            armed      <= 1'b0;
            press      <= 1'b0;
        end else begin
            sync_0   <= btn_n;
            btn_s    <= sync_0;
            warm     <= {warm[0], 1'b1};
            prev_lvl <= stable_lvl;

            if (btn_s == stable_lvl) begin
                counter <= '0;
            end else if (counter == CNT_LAST) begin
                stable_lvl <= btn_s;
                counter    <= '0;
            end else begin
                counter <= counter + CNT_W'(1);
            end

            if (warm[1] && btn_s) begin
                armed <= 1'b1;
            end

            press <= armed && prev_lvl && !stable_lvl;
        end
    end

endmodule

// File: rtl/value_loader.sv
// Captures one switch value per debounced press into a DEPTH-entry buffer and
// hands the complete set to the sorter over a valid/ready handshake.
module value_loader
    import loader_pkg::*;
#(
    parameter int DATA_W          = DEFAULT_DATA_W,
    parameter int DEPTH           = DEFAULT_DEPTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       btn_n,
    output logic [DEPTH*DATA_W-1:0]    entries,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = index_width(DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    load_state_e       state_q;
    load_state_e       state_d;
    logic              press;
    logic              load_en;
    logic              clear_en;
    logic [CNT_W-1:0]  count_q;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] entry_q [DEPTH];

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk  (clk),
        .rst  (rst),
        .btn_n(btn_n),
        .press(press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Presses are only honoured in LOAD; out_ready only matters in FULL.
    always_comb begin
        state_d   = state_q;
        load_en   = 1'b0;
        clear_en  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            LOAD: begin
                if (press) begin
                    load_en = 1'b1;
                    if (count_q == LAST_IDX) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    clear_en = 1'b1;
                    state_d  = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign wr_idx = count_q[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || clear_en) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (load_en) begin
            count_q <= count_q + CNT_W'(1);
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    entry_q[i] <= data_in;
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign entries[g*DATA_W +: DATA_W] = entry_q[g];
    end

    assign count = count_q;

endmodule

// File: tb/tb_value_loader.sv
// Randomized self-checking bench for value_loader: a queue-based reference
// model predicts each completed set, and a monitor checks it at the handshake.
module tb_value_loader;
    import loader_pkg::*;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int DEB    = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [DATA_W-1:0]       data_in = '0;
    logic                    btn_n = 1'b0;
    logic [DEPTH*DATA_W-1:0] entries;
    logic [CNT_W-1:0]        count;
    logic                    out_valid;
    logic                    out_ready = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    logic [DEPTH*DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0]       model_set [$];
    bit                      model_full = 1'b0;

    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;

    always #5 clk = ~clk;

    value_loader #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .btn_n(btn_n),
        .entries(entries),
        .count(count),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [DEPTH*DATA_W-1:0] packModel();
        logic [DEPTH*DATA_W-1:0] p;
        p = '0;
        for (int i = 0; i < model_set.size(); i++) begin
            p[i*DATA_W +: DATA_W] = model_set[i];
        end
        return p;
    endfunction

    // Reference behaviour: a clean press adds a value unless the set is full.
    task automatic modelPress(input logic [DATA_W-1:0] v);
        if (!model_full) begin
            model_set.push_back(v);
            if (model_set.size() == DEPTH) begin
                exp_q.push_back(packModel());
                model_full = 1'b1;
            end
        end
    endtask

    task automatic modelClear();
        model_set.delete();
        model_full = 1'b0;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_count"}, 32'(count), 32'(model_set.size()));
        checkOutput({tag, "_entries"}, 32'(entries), 32'(packModel()));
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'(model_full));
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] v, input int hold, input int rel);
        @(posedge clk);
        #1;
        data_in = v;
        btn_n   = 1'b0;
        modelPress(v);
        repeat (hold) @(posedge clk);
        #1 btn_n = 1'b1;
        repeat (rel) @(posedge clk);
        #1;
    endtask

    task automatic bounceGlitch(input int len);
        @(posedge clk);
        #1 btn_n = 1'b0;
        repeat (len) @(posedge clk);
        #1 btn_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic doHandshake();
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        modelClear();
    endtask

    // Monitor: checks each set when it is first offered and again when taken.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_valid: got valid with entries 0x%0h, expected no set", entries);
                end else begin
                    checkOutput("set_on_valid", 32'(entries), 32'(exp_q[0]));
                    checkOutput("count_on_valid", 32'(count), 32'(DEPTH));
                end
            end
            if (prev_valid && !out_valid && !prev_hs) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL valid_dropped: got valid=0, expected valid held until handshake");
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL handshake_unexpected: got entries 0x%0h, expected no set", entries);
                end else begin
                    checkOutput("set_at_handshake", 32'(entries), 32'(exp_q.pop_front()));
                end
            end
            prev_hs    = out_valid && out_ready;
            prev_valid = out_valid;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] v;

        // Reset with the button held; it must not produce a press afterwards.
        rst   = 1'b1;
        btn_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_entries", 32'(entries), 32'h0);
        checkOutput("reset_count", 32'(count), 32'h0);
        checkOutput("reset_valid", 32'(out_valid), 32'h0);
        repeat (12) @(posedge clk);
        #1 checkState("held_through_reset");
        btn_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            #1 btn_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 btn_n = 1'b1;
            repeat (2) @(posedge clk);
        end
        repeat (10) @(posedge clk);
        #1 checkState("bounce");

        applyStimulus(4'h9, 10, 10);
        checkState("load1");
        applyStimulus(4'h3, 10, 10);
        applyStimulus(4'hF, 10, 10);
        checkState("load3");
        applyStimulus(4'h1, 10, 10);
        checkOutput("clean_entries", 32'(entries), 32'h1F39);
        checkOutput("clean_valid", 32'(out_valid), 32'h1);

        applyStimulus(4'h7, 10, 10);
        applyStimulus(4'h7, 10, 10);
        checkOutput("full_hold_entries", 32'(entries), 32'h1F39);
        checkState("full_hold");

        // Handshake lands exactly on the press pulse, which must be dropped.
        @(posedge clk);
        #1;
        data_in = 4'hA;
        btn_n   = 1'b0;
        modelPress(4'hA);
        repeat (2 + DEB + 1) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        modelClear();
        checkState("after_handshake");
        repeat (6) @(posedge clk);
        #1 btn_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 checkState("press_on_handshake");

        applyStimulus(4'h5, 10, 10);
        applyStimulus(4'h6, 10, 10);
        checkState("midload");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        modelClear();
        checkState("after_midload_reset");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(4'h2, 10, 10);
        end
        checkOutput("reload_entries", 32'(entries), 32'h2222);
        checkOutput("reload_valid", 32'(out_valid), 32'h1);
        doHandshake();
        checkState("reload_handshake");

        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    bounceGlitch($urandom_range(1, 3));
                end
                v = DATA_W'($urandom_range(0, 15));
                applyStimulus(v, $urandom_range(10, 16), $urandom_range(10, 16));
                checkState("rand_load");
            end
            repeat ($urandom_range(0, 5)) @(posedge clk);
            v = DATA_W'($urandom_range(0, 15));
            applyStimulus(v, $urandom_range(10, 16), $urandom_range(10, 16));
            checkState("rand_full");
            doHandshake();
            checkState("rand_handshake");
        end

        repeat (4) @(posedge clk);
        #1 checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/value_loader.md
# value_loader

- Input-capture stage directly upstream of the sorting datapath.
- Debounces a raw pushbutton and captures one switch value per press into a DEPTH-entry buffer.
- When the buffer is full, presents the whole set to the sorter with a valid/ready handshake.
- Also exposes the partially loaded entries and the fill count so the top level can drive HEX/LEDR during entry.

## Interface
- DATA_W, 4, width of one entry (switch value)
- DEPTH, 4, number of entries per set
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (20 ms at 50 MHz)
- clk  in  1  system clock, single domain
- rst  in  1  synchronous, active-high reset
- data_in  in  DATA_W  switch value; sampled in the cycle the press pulse is active
- btn_n  in  1  raw active-low pushbutton; asynchronous and bouncy
- entries  out  DEPTH*DATA_W  captured set; entry i at [i*DATA_W +: DATA_W], entry 0 = first press
- count  out  $clog2(DEPTH+1)  number of entries captured, 0..DEPTH
- out_valid  out  1  set is complete and stable
- out_ready  in  1  sorter accepts the set (sorter idle)

## Operation
**Debouncer**
- btn_n passes through a 2-flop synchronizer to give btn_s.
- stable_lvl holds the last accepted level.
- The counter clears whenever btn_s == stable_lvl.
- While btn_s differs, the counter increments.
- When the counter reaches DEBOUNCE_CYCLES-1 with btn_s still differing:
  - stable_lvl <= btn_s
  - counter <= 0
- press is a registered one-cycle pulse, asserted the cycle after stable_lvl goes 1→0. Release generates no pulse.

**FSM**, states LOAD and FULL:
- **LOAD**
  - On press: entries[count] <= data_in and count <= count+1.
  - If count was DEPTH-1, the next state is FULL.
  - out_valid=0.
- **FULL**
  - out_valid=1; entries and count are frozen; press is ignored.
  - On out_valid && out_ready: entries <= 0, count <= 0, next state LOAD.
- out_ready is ignored in LOAD.
- A held button produces exactly one press; there is no auto-repeat.
- A bounce shorter than DEBOUNCE_CYCLES produces no press.

## Timing
- **Reset values:** sync flops=1, stable_lvl=1, counter=0, press=0, entries=0, count=0, out_valid=0, state=LOAD.
- **Press latency:** the press pulse appears 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after a clean btn_n falling edge.
- **Capture:** entry and count update on the clock edge ending the press cycle, i.e. visible 1 cycle after press.
- **Valid:** out_valid rises in the same cycle count becomes DEPTH. It stays high until the handshake; it is never dropped without handshake.
- **Handshake:** the transfer occurs on the edge where out_valid && out_ready are both 1. The next cycle has out_valid=0, count=0, entries=0.
- **Entry stability:** entries must not change while out_valid=1. The sorter may latch them on the handshake edge.
- **Press on the handshake cycle:** it is discarded; the state was FULL when the pulse occurred.
- **Reset mid-load or in FULL:** the partial or full set is discarded and all outputs return to reset values on the next edge. The debouncer also restarts, so a button held through reset yields a press only after release and re-press.
- **Widths:** count uses a $clog2(DEPTH+1)-bit counter and never wraps past DEPTH. The write index uses count's low $clog2(DEPTH) bits, valid only in LOAD.

## Structure
- **Package loader_pkg:** state enum (LOAD, FULL) and default DATA_W/DEPTH localparams, shared with the datapath so both agree on the packed entries layout.
- **Sub-module button_debouncer:** parameter DEBOUNCE_CYCLES; ports clk, rst, btn_n, press. It contains the synchronizer, counter, stable_lvl and edge pulse.
- **value_loader:** contains the FSM, the entry buffer and the count.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset:** assert rst 3 cycles with btn_n=0 → entries=0, count=0, out_valid=0; no press until btn_n released ≥4 cycles then pressed.
- **Bounce rejection:** btn_n toggles 0/1 every 2 cycles for 20 cycles, then returns to 1 → count stays 0.
- **Clean load:** press 4 times with data_in 9, 3, 0xF, 1 (each held 10 cycles, released 10 cycles) → entries=0x1F39, count=4, out_valid=1 in the cycle count hits 4.
- **Full hold:** with out_valid=1 and out_ready=0, press twice with data_in=7 → entries remain 0x1F39, count=4, out_valid=1.
- **Handshake:** raise out_ready 1 cycle → next cycle out_valid=0, count=0, entries=0. A press coinciding with the handshake cycle is not captured.
- **Reset mid-load:** after 2 presses (5, 6), pulse rst 1 cycle → count=0, entries=0. The next 4 presses (2, 2, 2, 2) give entries=0x2222, out_valid=1.
